// File: rtl/input_memory_read_arbiter_if.sv
// Controller-side input-memory read handshake.
// master = arbiter side, slave = ethernet controller side.
interface input_memory_read_arbiter_if #(
   parameter int ADDRESS_WIDTH   = 17,
   parameter int DATA_BYTE_WIDTH = 1
);
   logic                         inputMemoryReadReq;
   logic                         inputMemoryReadAck;
   logic [ADDRESS_WIDTH-1:0]     inputMemoryReadAdd;
   logic                         inputMemoryReadDataValid;
   logic [DATA_BYTE_WIDTH*8-1:0] inputMemoryReadData;

   modport master (
      output inputMemoryReadReq,
      output inputMemoryReadAdd,
      input  inputMemoryReadAck,
      input  inputMemoryReadDataValid,
      input  inputMemoryReadData
   );

   modport slave (
      input  inputMemoryReadReq,
      input  inputMemoryReadAdd,
      output inputMemoryReadAck,
      output inputMemoryReadDataValid,
      output inputMemoryReadData
   );
endinterface

// File: rtl/input_memory_read_arbiter.sv
// N-channel round-robin front end for the controller's input-memory read port.
// One request is forwarded at a time; accepted requests are tagged with their
// channel ID in an in-order tag FIFO so returned data is steered back to the
// originating channel. Data arriving with no outstanding tag is dropped and
// flagged with a sticky underflow error.
module input_memory_read_arbiter #(
   parameter int NUM_CHANNELS    = 4,
   parameter int CH_ID_WIDTH     = 2,
   parameter int ADDRESS_WIDTH   = 17,
   parameter int DATA_BYTE_WIDTH = 1,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                  userInterfaceClk,
   input  logic                                  userResetLow,
   input  logic [NUM_CHANNELS-1:0]               chReadReq,
   input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] chReadAdd,
   output logic [NUM_CHANNELS-1:0]               chReadAck,
   output logic [NUM_CHANNELS-1:0]               chReadDataValid,
   output logic [DATA_BYTE_WIDTH*8-1:0]          chReadData,
   input_memory_read_arbiter_if.master           mem,
   output logic [$clog2(MAX_OUTSTANDING):0]      outstandingCount,
   output logic                                  readUnderflowError
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);

   typedef enum logic {IDLE, REQUEST} state_t;

   state_t                      state_q;
   logic [CH_ID_WIDTH-1:0]      ptr_q;
   logic [CH_ID_WIDTH-1:0]      grant_q;
   logic [ADDRESS_WIDTH-1:0]    addr_q;
   logic                        req_q;

   logic [CH_ID_WIDTH-1:0]      tag_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]            wr_q;
   logic [PTR_W-1:0]            rd_q;
   logic [CNT_W-1:0]            count_q;

   logic                        dv_q;
   logic [CH_ID_WIDTH-1:0]      dv_ch_q;
   logic [DATA_BYTE_WIDTH*8-1:0] data_q;
   logic                        err_q;

   // Round-robin search: rotate requests so the pointer sits at bit 0, then
   // take the lowest set bit and rotate the offset back.
   logic [2*NUM_CHANNELS-1:0]   req_dbl;
   logic [NUM_CHANNELS-1:0]     req_rot;
   logic                        found;
   logic [CH_ID_WIDTH-1:0]      offset;
   logic [CH_ID_WIDTH:0]        pick_sum;
   logic [CH_ID_WIDTH-1:0]      grant_d;
   logic [ADDRESS_WIDTH-1:0]    addr_d;
   logic [CH_ID_WIDTH-1:0]      ptr_d;
   logic                        can_grant;
   logic                        accept;
   logic                        push;
   logic                        pop;
   logic                        underflow;

   assign req_dbl = {chReadReq, chReadReq};
   assign req_rot = req_dbl[ptr_q +: NUM_CHANNELS];

   // Priority-encode the rotated request vector (lowest index wins).
   always_comb begin
      found  = 1'b0;
      offset = '0;
      for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found  = 1'b1;
            offset = CH_ID_WIDTH'(k);
         end
      end
   end

   assign pick_sum  = {1'b0, ptr_q} + {1'b0, offset};
   assign grant_d   = (pick_sum >= (CH_ID_WIDTH+1)'(NUM_CHANNELS))
                      ? CH_ID_WIDTH'(pick_sum - (CH_ID_WIDTH+1)'(NUM_CHANNELS))
                      : CH_ID_WIDTH'(pick_sum);
   assign addr_d    = chReadAdd[int'(grant_d)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
   assign ptr_d     = (grant_q == CH_ID_WIDTH'(NUM_CHANNELS - 1)) ? '0 : grant_q + 1'b1;
   assign can_grant = found && (count_q < CNT_W'(MAX_OUTSTANDING));

   assign accept    = req_q && mem.inputMemoryReadAck;
   assign push      = accept;
   assign pop       = mem.inputMemoryReadDataValid && (count_q != '0);
   assign underflow = mem.inputMemoryReadDataValid && (count_q == '0);

   // Request FSM: latch the winner in IDLE, hold the request until accepted.
   always_ff @(posedge userInterfaceClk) begin
      if (!userResetLow) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (can_grant) begin
                  state_q <= REQUEST;
                  grant_q <= grant_d;
                  addr_q  <= addr_d;
                  req_q   <= 1'b1;
               end
            end
            REQUEST: begin
               if (mem.inputMemoryReadAck) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
                  ptr_q   <= ptr_d;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // Tag storage: written on acceptance, no reset needed for the contents.
   always_ff @(posedge userInterfaceClk) begin
      if (push) begin
         tag_mem[wr_q] <= grant_q;
      end
   end

   // Tag FIFO pointers and outstanding-read counter.
   always_ff @(posedge userInterfaceClk) begin
      if (!userResetLow) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Return path: register data and head tag for a one-cycle valid pulse.
   always_ff @(posedge userInterfaceClk) begin
      if (!userResetLow) begin
         dv_q    <= 1'b0;
         dv_ch_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         dv_q <= pop;
         if (pop) begin
            dv_ch_q <= tag_mem[rd_q];
            data_q  <= mem.inputMemoryReadData;
         end
         if (underflow) begin
            err_q <= 1'b1;
         end
      end
   end

   // One-hot steering of acknowledge and data-valid to the tagged channel.
   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_steer
      assign chReadAck[gi]       = accept && (grant_q == CH_ID_WIDTH'(gi));
      assign chReadDataValid[gi] = dv_q && (dv_ch_q == CH_ID_WIDTH'(gi));
   end

   assign mem.inputMemoryReadReq = req_q;
   assign mem.inputMemoryReadAdd = req_q ? addr_q : '0;
   assign chReadData             = data_q;
   assign outstandingCount       = count_q;
   assign readUnderflowError     = err_q;

endmodule

// File: tb/tb_input_memory_read_arbiter.sv
// Randomized and directed bench for input_memory_read_arbiter against a
// queue-based reference model of the arbitration and return rules.
module tb_input_memory_read_arbiter;
   localparam int N    = 4;
   localparam int CHW  = 2;
   localparam int AW   = 17;
   localparam int DBW  = 1;
   localparam int MAXO = 8;
   localparam int CW   = $clog2(MAXO) + 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       ch_req;
   logic [N*AW-1:0]    ch_add;
   logic [N-1:0]       ch_ack;
   logic [N-1:0]       ch_dv;
   logic [DBW*8-1:0]   ch_data;
   logic [CW-1:0]      count;
   logic               uerr;

   input_memory_read_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_BYTE_WIDTH(DBW)) mem_if ();

   input_memory_read_arbiter #(
      .NUM_CHANNELS(N), .CH_ID_WIDTH(CHW), .ADDRESS_WIDTH(AW),
      .DATA_BYTE_WIDTH(DBW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .userInterfaceClk   (clk),
      .userResetLow       (rst_n),
      .chReadReq          (ch_req),
      .chReadAdd          (ch_add),
      .chReadAck          (ch_ack),
      .chReadDataValid    (ch_dv),
      .chReadData         (ch_data),
      .mem                (mem_if),
      .outstandingCount   (count),
      .readUnderflowError (uerr)
   );

   always #5 clk = ~clk;

   typedef struct {int ch; logic [AW-1:0] addr;} rd_t;
   typedef struct {logic [AW-1:0] addr; int due;} ct_t;

   int n_vec = 0;
   int n_err = 0;

   // reference model
   bit            m_busy;
   int            m_gch;
   logic [AW-1:0] m_gaddr;
   int            m_ptr;
   int            tagq[$];
   bit            m_err;
   bit            m_dv;
   int            m_dvch;
   logic [7:0]    m_data;
   rd_t           sbq[$];

   // stimulus state
   ct_t           ctrlq[$];
   int            cyc = 0;
   bit            auto_ch = 0;
   int            p_req = 0;
   int            p_drop = 0;
   int            ctrl_mode = 3;
   logic [N-1:0]  ack_seen = '0;
   int            obs_acc[$];
   int            n_rreq = 0;
   ct_t           ct;
   bit            found;
   logic [AW-1:0] a1;

   function automatic logic [7:0] fdat(input logic [AW-1:0] a);
      return a[7:0] ^ a[15:8] ^ {7'b0, a[16]} ^ 8'hA5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
      end
   endtask

   // Compare DUT outputs to the model, then advance the model across one edge.
   task automatic step();
      logic [N-1:0] exp_ack;
      logic [N-1:0] exp_dv;
      bit           accept;
      int           cnt0;
      rd_t          e;
      #1;
      exp_ack = (m_busy && mem_if.inputMemoryReadAck) ? N'(1 << m_gch) : '0;
      exp_dv  = m_dv ? N'(1 << m_dvch) : '0;
      chk("rreq",  32'(mem_if.inputMemoryReadReq), 32'(m_busy));
      chk("radd",  32'(mem_if.inputMemoryReadAdd), m_busy ? 32'(m_gaddr) : 32'd0);
      chk("ack",   32'(ch_ack), 32'(exp_ack));
      chk("dv",    32'(ch_dv), 32'(exp_dv));
      chk("rdata", 32'(ch_data), 32'(m_data));
      chk("count", 32'(count), 32'(tagq.size()));
      chk("uerr",  32'(uerr), 32'(m_err));
      if (m_dv) begin
         if (sbq.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("e2e_ch",   32'(ch_dv), 32'(1 << e.ch));
            chk("e2e_data", 32'(ch_data), 32'(fdat(e.addr)));
         end
      end
      for (int k = 0; k < N; k++) if (ch_ack[k]) obs_acc.push_back(k);
      if (mem_if.inputMemoryReadReq) n_rreq++;
      ack_seen = exp_ack;

      if (!rst_n) begin
         m_busy = 0; m_gch = 0; m_gaddr = '0; m_ptr = 0; m_err = 0;
         m_dv = 0; m_dvch = 0; m_data = '0;
         tagq.delete(); sbq.delete(); ctrlq.delete();
      end else begin
         cnt0   = tagq.size();
         accept = m_busy && mem_if.inputMemoryReadAck;
         m_dv   = 0;
         if (mem_if.inputMemoryReadDataValid) begin
            if (cnt0 > 0) begin
               m_dv   = 1;
               m_dvch = tagq.pop_front();
               m_data = mem_if.inputMemoryReadData;
            end else begin
               m_err = 1;
            end
         end
         if (accept) begin
            tagq.push_back(m_gch);
            e.ch = m_gch; e.addr = m_gaddr;
            sbq.push_back(e);
            ct.addr = m_gaddr; ct.due = cyc + 3;
            ctrlq.push_back(ct);
            m_ptr  = (m_gch + 1) % N;
            m_busy = 0;
         end else if (!m_busy && cnt0 < MAXO && ch_req != '0) begin
            for (int k = N - 1; k >= 0; k--) begin
               if (ch_req[(m_ptr + k) % N]) m_gch = (m_ptr + k) % N;
            end
            m_busy  = 1;
            m_gaddr = ch_add[m_gch*AW +: AW];
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   // Drive channel requests and the controller according to the current mode.
   task automatic drive();
      ct_t c0;
      if (auto_ch) begin
         for (int c = 0; c < N; c++) begin
            if (ack_seen[c]) begin
               ch_req[c] = 1'b0;
            end else if (!ch_req[c]) begin
               if ($urandom_range(99) < p_req) begin
                  ch_req[c] = 1'b1;
                  ch_add[c*AW +: AW] = AW'($urandom);
               end
            end else if ($urandom_range(99) < p_drop) begin
               ch_req[c] = 1'b0;
            end
         end
      end
      case (ctrl_mode)
         0: begin
            mem_if.inputMemoryReadAck = ($urandom_range(99) < 60);
            mem_if.inputMemoryReadDataValid = 1'b0;
            mem_if.inputMemoryReadData = 8'($urandom);
            if (ctrlq.size() > 0 && $urandom_range(99) < 50) begin
               c0 = ctrlq.pop_front();
               mem_if.inputMemoryReadDataValid = 1'b1;
               mem_if.inputMemoryReadData = fdat(c0.addr);
            end
         end
         1: begin
            mem_if.inputMemoryReadAck = 1'b1;
            mem_if.inputMemoryReadDataValid = 1'b0;
            if (ctrlq.size() > 0 && ctrlq[0].due <= cyc) begin
               c0 = ctrlq.pop_front();
               mem_if.inputMemoryReadDataValid = 1'b1;
               mem_if.inputMemoryReadData = fdat(c0.addr);
            end
         end
         2: begin
            mem_if.inputMemoryReadAck = 1'b1;
            mem_if.inputMemoryReadDataValid = 1'b0;
         end
         default: ;
      endcase
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         step();
      end
   endtask

   initial begin
      rst_n = 1'b0; ch_req = '0; ch_add = '0;
      mem_if.inputMemoryReadAck = 1'b1;
      mem_if.inputMemoryReadDataValid = 1'b0;
      mem_if.inputMemoryReadData = '0;
      m_busy = 0; m_gch = 0; m_gaddr = '0; m_ptr = 0; m_err = 0;
      m_dv = 0; m_dvch = 0; m_data = '0;
      repeat (2) @(negedge clk);

      // reset held, then idle with Ack tied high
      repeat (2) step();
      rst_n = 1'b1;
      n_rreq = 0;
      repeat (10) step();
      chk("idle_noreq", 32'(n_rreq), 32'd0);

      // round-robin fairness, fixed 3-cycle return latency
      auto_ch = 1; p_req = 100; p_drop = 0; ctrl_mode = 1;
      obs_acc.delete();
      run(60);
      chk("rr_enough", 32'(obs_acc.size() >= 20), 32'd1);
      for (int i = 0; i < obs_acc.size(); i++) chk("rr_order", 32'(obs_acc[i]), 32'(i % N));
      auto_ch = 0; ch_req = '0;
      run(10);

      // outstanding limit with DataValid withheld
      auto_ch = 1; ctrl_mode = 2;
      obs_acc.delete();
      run(40);
      chk("lim_acks", 32'(obs_acc.size()), 32'd8);
      chk("lim_cnt", 32'(count), 32'd8);
      chk("lim_req", 32'(mem_if.inputMemoryReadReq), 32'd0);
      ctrl_mode = 3;
      ct = ctrlq.pop_front();
      mem_if.inputMemoryReadDataValid = 1'b1;
      mem_if.inputMemoryReadData = fdat(ct.addr);
      step();
      mem_if.inputMemoryReadDataValid = 1'b0;
      chk("lim_cnt7", 32'(count), 32'd7);
      ctrl_mode = 2;
      run(10);
      chk("lim_one_more", 32'(obs_acc.size()), 32'd9);
      chk("lim_cnt8", 32'(count), 32'd8);
      auto_ch = 0; ch_req = '0;
      rst_n = 1'b0; step(); rst_n = 1'b1;

      // simultaneous push and pop at count 1
      ctrl_mode = 3;
      mem_if.inputMemoryReadAck = 1'b1;
      a1 = 17'h1_2345;
      ch_add[1*AW +: AW] = a1; ch_req = 4'b0010;
      step(); step();
      ch_req = 4'b0000;
      chk("pp_cnt1", 32'(count), 32'd1);
      ch_add[3*AW +: AW] = 17'h0_0F0F; ch_req = 4'b1000;
      step();
      ct = ctrlq.pop_front();
      mem_if.inputMemoryReadDataValid = 1'b1;
      mem_if.inputMemoryReadData = fdat(ct.addr);
      step();
      ch_req = '0;
      mem_if.inputMemoryReadDataValid = 1'b0;
      chk("pp_cnt", 32'(count), 32'd1);
      chk("pp_tag", 32'(ch_dv), 32'b0010);
      chk("pp_data", 32'(ch_data), 32'(fdat(a1)));
      ctrl_mode = 1;
      run(8);

      // underflow: DataValid with nothing outstanding
      ctrl_mode = 3;
      chk("uf_cnt0", 32'(count), 32'd0);
      mem_if.inputMemoryReadDataValid = 1'b1;
      mem_if.inputMemoryReadData = 8'h3C;
      step();
      mem_if.inputMemoryReadDataValid = 1'b0;
      chk("uf_dv", 32'(ch_dv), 32'd0);
      chk("uf_err", 32'(uerr), 32'd1);
      repeat (5) step();
      chk("uf_sticky", 32'(uerr), 32'd1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk("uf_clr", 32'(uerr), 32'd0);

      // reset in REQUEST with 3 reads outstanding
      auto_ch = 1; p_req = 100; p_drop = 0; ctrl_mode = 2;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         drive();
         step();
         if (tagq.size() == 3 && m_busy) found = 1;
      end
      chk("rm_reach", 32'(found), 32'd1);
      auto_ch = 0; ch_req = '1;
      rst_n = 1'b0;
      step();
      chk("rm_rreq", 32'(mem_if.inputMemoryReadReq), 32'd0);
      chk("rm_ack", 32'(ch_ack), 32'd0);
      chk("rm_dv", 32'(ch_dv), 32'd0);
      chk("rm_cnt", 32'(count), 32'd0);
      rst_n = 1'b1;
      obs_acc.delete();
      step(); step();
      chk("rm_ptr", (obs_acc.size() > 0) ? 32'(obs_acc[0]) : 32'hFFFF_FFFF, 32'd0);
      ch_req = '0;
      rst_n = 1'b0; step(); rst_n = 1'b1;

      // random traffic
      auto_ch = 1; p_req = 30; p_drop = 5; ctrl_mode = 0;
      run(3000);
      auto_ch = 0; ch_req = '0; ctrl_mode = 1;
      run(20);
      chk("final_cnt", 32'(count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
